// File: rtl/mem_port_arbiter.sv
// Two-port arbiter sharing one single-cycle-read memory between an
// instruction-fetch port and a data port. Data wins by default; fetch is
// forced through after STARVE_LIMIT consecutive denied cycles.
module mem_port_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 10,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  dm_req,
  input  logic                  dm_we,
  input  logic [ADDR_WIDTH-1:0] dm_addr,
  input  logic [DATA_WIDTH-1:0] dm_wdata,
  input  logic [3:0]            dm_be,
  output logic                  dm_gnt,
  output logic                  dm_rvalid,
  output logic [DATA_WIDTH-1:0] dm_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [3:0]            mem_be,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int unsigned CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RESP_IF = 2'd1,
    RESP_DM = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic             dm_we_q, dm_we_d;
  logic             fetch_force;

  // Grant selection: data first unless fetch has been starved to the limit.
  always_comb begin
    fetch_force = if_req && (starve_cnt_q == CNT_MAX);
    if_gnt      = 1'b0;
    dm_gnt      = 1'b0;
    if (!reset) begin
      if (if_req && (fetch_force || !dm_req)) begin
        if_gnt = 1'b1;
      end else if (dm_req) begin
        dm_gnt = 1'b1;
      end
    end
  end

  // Starvation counter and latched store/load flag for the pending data response.
  always_comb begin
    if (if_req && !if_gnt) begin
      starve_cnt_d = (starve_cnt_q == CNT_MAX) ? CNT_MAX : starve_cnt_q + CNT_W'(1);
    end else begin
      starve_cnt_d = '0;
    end
    dm_we_d = dm_gnt ? dm_we : dm_we_q;
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
      dm_we_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      dm_we_q      <= dm_we_d;
    end
  end

  // Next state: the response slot always belongs to this cycle's grant.
  always_comb begin
    state_d = IDLE;
    if (if_gnt) begin
      state_d = RESP_IF;
    end else if (dm_gnt) begin
      state_d = RESP_DM;
    end
  end

  // Response outputs, suppressed while reset is held so a pending response is dropped.
  always_comb begin
    if_rvalid = 1'b0;
    if_rdata  = '0;
    dm_rvalid = 1'b0;
    dm_rdata  = '0;
    if (!reset) begin
      case (state_q)
        RESP_IF: begin
          if_rvalid = 1'b1;
          if_rdata  = mem_rdata;
        end
        RESP_DM: begin
          dm_rvalid = 1'b1;
          dm_rdata  = dm_we_q ? '0 : mem_rdata;
        end
        default: ;
      endcase
    end
  end

  // Memory request mux driven by the granted port.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (if_gnt) begin
      mem_en   = 1'b1;
      mem_be   = '1;
      mem_addr = if_addr;
    end else if (dm_gnt) begin
      mem_en    = 1'b1;
      mem_we    = dm_we;
      mem_be    = dm_be;
      mem_addr  = dm_addr;
      mem_wdata = dm_wdata;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a driver issues per-cycle vectors and
// pushes expected responses; a negedge monitor pops and compares them.
module tb_mem_port_arbiter;

  logic        clk;
  logic        reset;
  logic        if_req;
  logic [9:0]  if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        dm_req;
  logic        dm_we;
  logic [9:0]  dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_be;
  logic        dm_gnt;
  logic        dm_rvalid;
  logic [31:0] dm_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  mem_port_arbiter #(
    .ADDR_WIDTH(10),
    .DATA_WIDTH(32),
    .STARVE_LIMIT(4)
  ) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_be(dm_be), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  typedef struct {
    int          due;
    logic [31:0] data;
  } resp_t;

  resp_t       ifq[$];
  resp_t       dmq[$];
  int          pass_cnt = 0;
  int          total_cnt = 0;
  int          cyc_n = 0;
  logic [31:0] tbmem [0:1023];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Memory model: registered read, byte-masked write, junk when not reading.
  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) tbmem[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
    end
    if (mem_en && !mem_we) mem_rdata <= tbmem[mem_addr];
    else                   mem_rdata <= 32'hA5A5_0000 | cyc_n[15:0];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc_n, act, exp);
  endtask

  // Response monitor.
  always @(negedge clk) begin
    if (cyc_n >= 1) begin
      if (if_rvalid === 1'b1) begin
        if (ifq.size() == 0) begin
          chk("if_rvalid_unexpected", 32'd1, 32'd0);
        end else begin
          resp_t e;
          e = ifq.pop_front();
          chk("if_resp_cycle", cyc_n, e.due);
          chk("if_rdata", if_rdata, e.data);
        end
      end else begin
        if (ifq.size() > 0 && ifq[0].due <= cyc_n) begin
          void'(ifq.pop_front());
          chk("if_rvalid_missing", {31'd0, if_rvalid}, 32'd1);
        end
        chk("if_rdata_idle_zero", if_rdata, 32'd0);
      end
      if (dm_rvalid === 1'b1) begin
        if (dmq.size() == 0) begin
          chk("dm_rvalid_unexpected", 32'd1, 32'd0);
        end else begin
          resp_t e;
          e = dmq.pop_front();
          chk("dm_resp_cycle", cyc_n, e.due);
          chk("dm_rdata", dm_rdata, e.data);
        end
      end else begin
        if (dmq.size() > 0 && dmq[0].due <= cyc_n) begin
          void'(dmq.pop_front());
          chk("dm_rvalid_missing", {31'd0, dm_rvalid}, 32'd1);
        end
        chk("dm_rdata_idle_zero", dm_rdata, 32'd0);
      end
    end
  end

  // One cycle: drive vector, check grant/memory side at negedge, queue responses.
  task automatic step(input logic rst, input logic ifr, input logic [9:0] ia,
                      input logic dr, input logic dw, input logic [9:0] da,
                      input logic [31:0] wd, input logic [3:0] be,
                      input logic eig, input logic edg,
                      input logic [31:0] exp_rd, input logic push);
    resp_t e;
    reset = rst; if_req = ifr; if_addr = ia;
    dm_req = dr; dm_we = dw; dm_addr = da; dm_wdata = wd; dm_be = be;
    @(negedge clk);
    chk("if_gnt", {31'd0, if_gnt}, {31'd0, eig});
    chk("dm_gnt", {31'd0, dm_gnt}, {31'd0, edg});
    chk("mem_en", {31'd0, mem_en}, {31'd0, eig | edg});
    if (eig) begin
      chk("mem_addr_if", {22'd0, mem_addr}, {22'd0, ia});
      chk("mem_we_if", {31'd0, mem_we}, 32'd0);
      chk("mem_be_if", {28'd0, mem_be}, 32'hF);
    end else if (edg) begin
      chk("mem_addr_dm", {22'd0, mem_addr}, {22'd0, da});
      chk("mem_we_dm", {31'd0, mem_we}, {31'd0, dw});
      chk("mem_be_dm", {28'd0, mem_be}, {28'd0, be});
      if (dw) chk("mem_wdata", mem_wdata, wd);
    end else begin
      chk("mem_we_idle", {31'd0, mem_we}, 32'd0);
    end
    if (rst) begin
      chk("rst_mem_addr", {22'd0, mem_addr}, 32'd0);
      chk("rst_mem_be", {28'd0, mem_be}, 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);
      chk("rst_if_rvalid", {31'd0, if_rvalid}, 32'd0);
      chk("rst_dm_rvalid", {31'd0, dm_rvalid}, 32'd0);
      chk("rst_if_rdata", if_rdata, 32'd0);
      chk("rst_dm_rdata", dm_rdata, 32'd0);
    end
    e.due  = cyc_n + 1;
    e.data = exp_rd;
    if (push && eig) ifq.push_back(e);
    if (push && edg) dmq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 1024; i++) tbmem[i] = 32'h1000_0000 + i;
    tbmem[4] = 32'h0050_0093;
    mem_rdata = '0;
    //    rst ifr ia      dr dw da      wd            be      eig  edg  exp_rd        push
    // Reset held with both ports requesting: nothing granted.
    step(1, 1, 10'h004, 1, 0, 10'h010, 32'h0, 4'hF, 0, 0, 32'h0, 0);
    step(1, 1, 10'h004, 1, 0, 10'h010, 32'h0, 4'hF, 0, 0, 32'h0, 0);
    step(0, 0, 10'h000, 0, 0, 10'h000, 32'h0, 4'h0, 0, 0, 32'h0, 0);
    // Fetch only.
    step(0, 1, 10'h004, 0, 0, 10'h000, 32'h0, 4'h0, 1, 0, 32'h0050_0093, 1);
    // Collision: data load wins, fetch waits then goes through.
    step(0, 1, 10'h008, 1, 0, 10'h010, 32'h0, 4'hF, 0, 1, 32'h1000_0010, 1);
    step(0, 1, 10'h008, 0, 0, 10'h000, 32'h0, 4'h0, 1, 0, 32'h1000_0008, 1);
    // Store with partial byte enables, then read back the merged word.
    step(0, 0, 10'h000, 1, 1, 10'h020, 32'hDEAD_BEEF, 4'b0011, 0, 1, 32'h0, 1);
    step(0, 0, 10'h000, 1, 0, 10'h020, 32'h0, 4'hF, 0, 1, 32'h1000_BEEF, 1);
    // Back-to-back fetches.
    step(0, 1, 10'h000, 0, 0, 10'h000, 32'h0, 4'h0, 1, 0, 32'h1000_0000, 1);
    step(0, 1, 10'h001, 0, 0, 10'h000, 32'h0, 4'h0, 1, 0, 32'h1000_0001, 1);
    step(0, 1, 10'h002, 0, 0, 10'h000, 32'h0, 4'h0, 1, 0, 32'h1000_0002, 1);
    // Starvation: four data wins, forced fetch, then counter cleared so data wins again.
    step(0, 1, 10'h030, 1, 0, 10'h041, 32'h0, 4'hF, 0, 1, 32'h1000_0041, 1);
    step(0, 1, 10'h030, 1, 0, 10'h042, 32'h0, 4'hF, 0, 1, 32'h1000_0042, 1);
    step(0, 1, 10'h030, 1, 0, 10'h043, 32'h0, 4'hF, 0, 1, 32'h1000_0043, 1);
    step(0, 1, 10'h030, 1, 0, 10'h044, 32'h0, 4'hF, 0, 1, 32'h1000_0044, 1);
    step(0, 1, 10'h030, 1, 0, 10'h045, 32'h0, 4'hF, 1, 0, 32'h1000_0030, 1);
    step(0, 1, 10'h031, 1, 0, 10'h045, 32'h0, 4'hF, 0, 1, 32'h1000_0045, 1);
    step(0, 1, 10'h031, 0, 0, 10'h000, 32'h0, 4'h0, 1, 0, 32'h1000_0031, 1);
    // Fetch withdrawn before grant: no access, no response.
    step(0, 1, 10'h050, 1, 0, 10'h051, 32'h0, 4'hF, 0, 1, 32'h1000_0051, 1);
    step(0, 0, 10'h050, 0, 0, 10'h000, 32'h0, 4'h0, 0, 0, 32'h0, 0);
    // Fetch granted then reset: its response is discarded.
    step(0, 1, 10'h004, 0, 0, 10'h000, 32'h0, 4'h0, 1, 0, 32'h0, 0);
    step(1, 0, 10'h000, 0, 0, 10'h000, 32'h0, 4'h0, 0, 0, 32'h0, 0);
    step(0, 0, 10'h000, 0, 0, 10'h000, 32'h0, 4'h0, 0, 0, 32'h0, 0);
    // Normal operation resumes after reset.
    step(0, 1, 10'h001, 0, 0, 10'h000, 32'h0, 4'h0, 1, 0, 32'h1000_0001, 1);
    step(0, 0, 10'h000, 0, 0, 10'h000, 32'h0, 4'h0, 0, 0, 32'h0, 0);
    step(0, 0, 10'h000, 0, 0, 10'h000, 32'h0, 4'h0, 0, 0, 32'h0, 0);
    chk("ifq_drained", ifq.size(), 32'd0);
    chk("dmq_drained", dmq.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: ADDR_WIDTH, default 10, word-address width of the shared memory.
REQ-002 Parameter: DATA_WIDTH, default 32, data word width.
REQ-003 Parameter: STARVE_LIMIT, default 4, number of consecutive denied fetch cycles before fetch is forced to win.
REQ-004 Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- if_req  in  1  fetch read request.
- if_addr  in  ADDR_WIDTH  fetch word address.
- if_gnt  out  1  fetch request accepted this cycle.
- if_rvalid  out  1  fetch read data valid.
- if_rdata  out  DATA_WIDTH  fetch read data.
- dm_req  in  1  data-port request.
- dm_we  in  1  1 = store, 0 = load.
- dm_addr  in  ADDR_WIDTH  data word address.
- dm_wdata  in  DATA_WIDTH  store data.
- dm_be  in  4  store byte enables.
- dm_gnt  out  1  data request accepted this cycle.
- dm_rvalid  out  1  data response: load data valid, or store acknowledged.
- dm_rdata  out  DATA_WIDTH  load data.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_be  out  4  memory byte enables.
- mem_addr  out  ADDR_WIDTH  memory word address.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_rdata  in  DATA_WIDTH  memory read data; valid exactly 1 cycle after an accepted read.

Function
REQ-005 The block SHALL grant at most one requester per cycle; if_gnt and dm_gnt SHALL never both be 1.
REQ-006 Grants SHALL be combinational from the current requests and state; a requester SHALL hold its req, address and data stable until the cycle its gnt is 1.
REQ-007 In a grant cycle, mem_en SHALL be 1 and mem_addr/mem_we/mem_be/mem_wdata SHALL come from the granted requester; fetch drives mem_we=0 and mem_be=4'b1111.
REQ-008 With no grant, mem_en and mem_we SHALL be 0.
REQ-009 Default priority: data over fetch.
REQ-010 starve_cnt SHALL increment each cycle if_req=1 and if_gnt=0. It SHALL clear on if_gnt=1 or if_req=0, and saturate at STARVE_LIMIT.
REQ-011 When starve_cnt == STARVE_LIMIT and if_req=1, fetch SHALL win over data that cycle.
REQ-012 The response FSM SHALL have three states: IDLE (no response due), RESP_IF (fetch response due), RESP_DM (data response due).
REQ-013 From any state, the next state SHALL be RESP_IF on if_gnt, RESP_DM on dm_gnt, and IDLE otherwise.
REQ-014 Back-to-back grants SHALL be allowed every cycle, for 100% port throughput.
REQ-015 In RESP_IF, if_rvalid SHALL be 1 and if_rdata SHALL equal mem_rdata.
REQ-016 In RESP_DM, dm_rvalid SHALL be 1. dm_rdata SHALL equal mem_rdata for a load and 0 for a store (latched dm_we).
REQ-017 Outside their response state, if_rvalid and dm_rvalid SHALL be 0 and if_rdata and dm_rdata SHALL be 0.
REQ-018 Latency: the response SHALL occur exactly 1 cycle after the grant, with no other latency permitted.
REQ-019 Simultaneous new grant and pending response: both SHALL occur in the same cycle, and the response SHALL belong to the previous grant.
REQ-020 A request deasserted before its grant SHALL produce no memory access and no response.

Reset
REQ-021 While reset=1, the FSM SHALL be IDLE and starve_cnt SHALL be 0.
REQ-022 While reset=1, if_gnt, dm_gnt, mem_en, mem_we, if_rvalid and dm_rvalid SHALL all be 0, and mem_be, mem_addr, mem_wdata, if_rdata and dm_rdata SHALL be 0.
REQ-023 Reset asserted with a response pending SHALL discard that response; no rvalid SHALL appear in the cycle after reset deasserts.
REQ-024 Reset SHALL take effect on the first rising edge at which it is sampled high.

Verification
REQ-025 Fetch only: if_req=1, if_addr=0x004 -> if_gnt=1, mem_en=1, mem_addr=0x004; next cycle if_rvalid=1, if_rdata=mem_rdata (e.g. 0x00500093).
REQ-026 Collision: if_req=dm_req=1 with a load at 0x010 -> dm_gnt=1 and if_gnt=0; next cycle dm_rvalid=1 with dm_rdata=mem_rdata, while the fetch waits.
REQ-027 Starvation: dm_req held at 1 and if_req held at 1 for 5 cycles, STARVE_LIMIT=4 -> dm_gnt in cycles 0-3, if_gnt in cycle 4, starve_cnt=0 in cycle 5.
REQ-028 Store: dm_req=1, dm_we=1, dm_addr=0x020, dm_wdata=0xDEADBEEF, dm_be=4'b0011 -> mem_we=1, mem_be=4'b0011; next cycle dm_rvalid=1, dm_rdata=0.
REQ-029 Back-to-back: fetches at 0x000, 0x001 and 0x002 on consecutive cycles -> three consecutive if_rvalid pulses, in order, with no bubble.
REQ-030 Reset mid-operation: reset=1 in the cycle after an if_gnt -> if_rvalid=0 and all grants 0; after reset deasserts, the FSM is IDLE and no stale response appears.
